// File: rtl/state_loader.sv
// rtl/state_loader.sv - ping-pong word-to-16-byte state array staging buffer
//
// Assembles a stream of WORD_W-bit words into 16-byte blocks. It uses two
// slots, so one block can fill while the other is held for the round logic.
//
// Ports:
//   clk             rising-edge clock
//   n_rst           asynchronous active-low reset
//   clear           synchronous abort; drops partial and stored blocks
//   word_in         input word; its MSB byte goes to the lowest state index
//   word_valid      word_in is valid
//   word_ready      a word can be accepted this cycle
//   state_array_out 16 bytes of the block at the read slot; [0] = first byte
//   block_valid     state_array_out holds a complete block
//   block_ready     downstream consumes the block this cycle
//   partial         the fill slot holds 1..WPB-1 words
//   block_cnt       blocks released downstream; wraps at 16 bits
module state_loader #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic [7:0]        state_array_out [0:15],
   output logic              block_valid,
   input  logic              block_ready,
   output logic              partial,
   output logic [15:0]       block_cnt
);

   localparam int BPW = WORD_W / 8;
   localparam int WPB = 16 / BPW;
   localparam int CW  = $clog2(WPB);
   localparam logic [CW-1:0] LAST_WORD = CW'(WPB - 1);

   logic [7:0]    slot0 [0:15];
   logic [7:0]    slot1 [0:15];
   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic          wr_sel;
   logic          rd_sel;
   logic [CW-1:0] wcnt;

   logic          accept;
   logic          release_blk;
   logic          last_word;
   logic [3:0]    base;

   assign word_ready  = !full[wr_sel];
   assign block_valid = full[rd_sel];
   assign partial     = (wcnt != '0);

   always_comb begin
      accept      = word_valid && word_ready;
      release_blk = block_valid && block_ready;
      last_word   = (wcnt == LAST_WORD);
      base        = 4'(wcnt) * 4'(BPW);
      // Completion and release touch different slots. When both slots are
      // full, word_ready is low, so no completion can collide with a release.
      full_nxt = full;
      if (release_blk)
         full_nxt[rd_sel] = 1'b0;
      if (accept && last_word)
         full_nxt[wr_sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         full      <= 2'b00;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         wcnt      <= '0;
         block_cnt <= 16'd0;
      end else if (clear) begin
         // clear takes priority. Slot data is kept, and a release in the
         // same edge is not counted.
         full   <= 2'b00;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wcnt   <= '0;
      end else begin
         full <= full_nxt;
         if (accept) begin
            if (last_word) begin
               wcnt   <= '0;
               wr_sel <= !wr_sel;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
         end
         if (release_blk) begin
            rd_sel    <= !rd_sel;
            block_cnt <= block_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 16; i++) begin
            slot0[i] <= 8'h00;
            slot1[i] <= 8'h00;
         end
      end else if (accept && !clear) begin
         for (int k = 0; k < BPW; k++) begin
            if (wr_sel)
               slot1[base + 4'(k)] <= word_in[WORD_W-1-8*k -: 8];
            else
               slot0[base + 4'(k)] <= word_in[WORD_W-1-8*k -: 8];
         end
      end
   end

   // The output is only a 2:1 mux over registered bytes.
   always_comb begin
      for (int i = 0; i < 16; i++)
         state_array_out[i] = rd_sel ? slot1[i] : slot0[i];
   end

endmodule

// File: tb/tb_state_loader.sv
// tb/tb_state_loader.sv - directed self-checking bench for state_loader
module tb_state_loader;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;

   logic        clear = 1'b0;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        word_ready;
   logic [7:0]  sa [0:15];
   logic        block_valid;
   logic        block_ready = 1'b0;
   logic        partial;
   logic [15:0] block_cnt;

   logic        clear8 = 1'b0;
   logic [7:0]  word_in8 = '0;
   logic        word_valid8 = 1'b0;
   logic        word_ready8;
   logic [7:0]  sa8 [0:15];
   logic        block_valid8;
   logic        block_ready8 = 1'b0;
   logic        partial8;
   logic [15:0] block_cnt8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   state_loader #(.WORD_W(32)) u32 (
      .clk(clk), .n_rst(n_rst), .clear(clear),
      .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
      .state_array_out(sa), .block_valid(block_valid), .block_ready(block_ready),
      .partial(partial), .block_cnt(block_cnt)
   );

   state_loader #(.WORD_W(8)) u8 (
      .clk(clk), .n_rst(n_rst), .clear(clear8),
      .word_in(word_in8), .word_valid(word_valid8), .word_ready(word_ready8),
      .state_array_out(sa8), .block_valid(block_valid8), .block_ready(block_ready8),
      .partial(partial8), .block_cnt(block_cnt8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send32(input logic [31:0] w);
      word_in    = w;
      word_valid = 1'b1;
      step();
      word_valid = 1'b0;
   endtask

   initial begin
      // Reset values
      #2;
      chk("rst_block_valid", block_valid, 0);
      chk("rst_word_ready", word_ready, 1);
      chk("rst_partial", partial, 0);
      chk("rst_sa0", sa[0], 8'h00);
      chk("rst_cnt", block_cnt, 0);
      step();
      n_rst = 1'b1;

      // 1: single block load
      send32(32'h6c756b65);
      chk("t1_partial_w1", partial, 1);
      send32(32'h696d796f);
      send32(32'h75726661);
      chk("t1_bv_before_last", block_valid, 0);
      send32(32'h74686572);
      chk("t1_bv_after_last", block_valid, 1);
      chk("t1_partial_after", partial, 0);
      chk("t1_sa0", sa[0], 8'h6c);
      chk("t1_sa1", sa[1], 8'h75);
      chk("t1_sa4", sa[4], 8'h69);
      chk("t1_sa15", sa[15], 8'h72);
      block_ready = 1'b1;
      step();
      block_ready = 1'b0;
      chk("t1_cnt", block_cnt, 1);
      chk("t1_bv_drained", block_valid, 0);

      // 2: backpressure; stream byte j has value j
      for (int i = 0; i < 8; i++) begin
         chk("t2_ready_fill", word_ready, 1);
         send32(32'h00010203 + 32'h04040404 * i);
      end
      chk("t2_ready_low", word_ready, 0);
      chk("t2_bv", block_valid, 1);
      chk("t2_b1_sa0", sa[0], 8'h00);
      chk("t2_b1_sa15", sa[15], 8'h0f);
      word_in    = 32'h00010203 + 32'h04040404 * 8;
      word_valid = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step();
         chk("t2_stall_ready", word_ready, 0);
         chk("t2_stall_partial", partial, 0);
         chk("t2_stall_sa15", sa[15], 8'h0f);
      end
      block_ready = 1'b1;
      step();
      block_ready = 1'b0;
      chk("t2_cnt_after_rel", block_cnt, 2);
      chk("t2_ready_back", word_ready, 1);
      chk("t2_b2_bv", block_valid, 1);
      chk("t2_b2_sa0", sa[0], 8'h10);
      chk("t2_b2_sa15", sa[15], 8'h1f);
      for (int i = 8; i < 12; i++) begin
         word_in = 32'h00010203 + 32'h04040404 * i;
         step();
      end
      word_valid = 1'b0;
      chk("t2_both_full_ready", word_ready, 0);
      chk("t2_b2_still_sa0", sa[0], 8'h10);
      block_ready = 1'b1;
      step();
      chk("t2_b3_sa0", sa[0], 8'h20);
      chk("t2_b3_sa15", sa[15], 8'h2f);
      step();
      block_ready = 1'b0;
      chk("t2_cnt_drained", block_cnt, 4);
      chk("t2_bv_drained", block_valid, 0);

      // 3: streaming with block_ready high
      block_ready = 1'b1;
      word_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_ready", word_ready, 1);
         word_in = 32'ha0000000 | 32'(i);
         step();
         chk("t3_cnt", block_cnt, (i < 4) ? 4 : 5);
      end
      word_valid = 1'b0;
      chk("t3_bv_b2", block_valid, 1);
      chk("t3_b2_sa15", sa[15], 8'h07);
      chk("t3_b2_sa0", sa[0], 8'ha0);
      step();
      block_ready = 1'b0;
      chk("t3_cnt_final", block_cnt, 6);
      chk("t3_bv_final", block_valid, 0);

      // 4: clear mid-fill
      send32(32'hdeadbeef);
      send32(32'h01020304);
      chk("t4_partial_before", partial, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t4_partial_after", partial, 0);
      chk("t4_cnt_held", block_cnt, 6);
      chk("t4_bv_after_clear", block_valid, 0);
      send32(32'h00112233);
      send32(32'h44556677);
      send32(32'h8899aabb);
      send32(32'hccddeeff);
      chk("t4_bv", block_valid, 1);
      chk("t4_sa0", sa[0], 8'h00);
      chk("t4_sa5", sa[5], 8'h55);
      chk("t4_sa15", sa[15], 8'hff);
      clear       = 1'b1;
      block_ready = 1'b1;
      step();
      clear       = 1'b0;
      block_ready = 1'b0;
      chk("t4_clear_beats_release_cnt", block_cnt, 6);
      chk("t4_clear_bv", block_valid, 0);
      chk("t4_data_kept_sa15", sa[15], 8'hff);

      // 5: asynchronous reset with block held and wcnt=3
      for (int i = 0; i < 7; i++)
         send32(32'h11111111 * (i + 1));
      chk("t5_bv_pre", block_valid, 1);
      chk("t5_partial_pre", partial, 1);
      #3;
      n_rst = 1'b0;
      #1;
      chk("t5_async_bv", block_valid, 0);
      chk("t5_async_ready", word_ready, 1);
      chk("t5_async_partial", partial, 0);
      chk("t5_async_sa0", sa[0], 8'h00);
      chk("t5_async_cnt", block_cnt, 0);
      step();
      n_rst = 1'b1;
      send32(32'hcafef00d);
      send32(32'h01234567);
      send32(32'h89abcdef);
      send32(32'h5a5aa5a5);
      chk("t5_bv", block_valid, 1);
      chk("t5_sa0", sa[0], 8'hca);
      chk("t5_sa4", sa[4], 8'h01);
      chk("t5_sa15", sa[15], 8'ha5);

      // 6: 8-bit instance
      word_valid8 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         word_in8 = 8'(i);
         step();
         if (i < 15) begin
            chk("t6_partial", partial8, 1);
            chk("t6_bv_early", block_valid8, 0);
         end
      end
      word_valid8 = 1'b0;
      chk("t6_bv", block_valid8, 1);
      chk("t6_partial_done", partial8, 0);
      for (int i = 0; i < 16; i++)
         chk("t6_sa", sa8[i], 32'(i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/state_loader.md
Name: state_loader

Overview:
Input staging buffer that sits directly upstream of sub_byte. It accepts plaintext (or round state) as a stream of words over a valid/ready handshake and assembles each group into a 16-byte state array. It presents the completed array as state_array_out[0:15], which wires straight to sub_byte.state_array_in. The buffer is ping-pong (two slots), so the next block can be loaded while the current one is held for the round logic.

Parameters:
WORD_W, 32, input word width in bits; legal values 8, 16, 32.
(derived) BPW = WORD_W/8 bytes per word; WPB = 16/BPW words per block.

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: discards partial and stored blocks
word_in  input  WORD_W  input data word; most significant byte is the lowest state index
word_valid  input  1  word_in is valid
word_ready  output  1  loader can accept word_in this cycle
state_array_out  output  8 x [0:15]  unpacked byte array; index 0 = first byte received
block_valid  output  1  state_array_out holds a complete block
block_ready  input  1  downstream consumes the block this cycle
partial  output  1  high when the fill slot holds 1..WPB-1 words
block_cnt  output  16  count of blocks released downstream; wraps at 0xFFFF -> 0

Behaviour:
- Storage: two slots of 16 bytes each. Also held: wr_sel, rd_sel (1 bit each), full[1:0], and word counter wcnt with range 0..WPB-1.
- Reset (n_rst low, asynchronous): all slot bytes 0x00, full=00, wr_sel=rd_sel=0, wcnt=0, block_cnt=0.
- Output values in reset: block_valid=0, word_ready=1, partial=0, state_array_out all 0x00.
- word_ready = !full[wr_sel]. It is a pure function of registered state; there is no combinational path from block_ready or word_valid.
- Word accept happens on word_valid && word_ready at a rising edge:
  - word_in[WORD_W-1-8k -: 8] is written to slot[wr_sel] byte (wcnt*BPW + k), for k = 0..BPW-1.
  - If wcnt == WPB-1: full[wr_sel] <= 1, wr_sel toggles, wcnt <= 0.
  - Otherwise wcnt increments.
- word_valid while word_ready=0 is ignored; no data is written and wcnt is unchanged.
- block_valid = full[rd_sel]. state_array_out = slot[rd_sel] (registered bytes through a 2:1 mux; no other logic).
- Block release happens on block_valid && block_ready at a rising edge: full[rd_sel] <= 0, rd_sel toggles, block_cnt increments.
- While block_valid=1 and block_ready=0, state_array_out and block_valid are stable.
- Latency: the edge that accepts the last word of a block sets block_valid from the next cycle, provided the other slot is empty.
- Simultaneous completion and release in the same edge both take effect. The full bits refer to different slots except in the both-full case, where word_ready=0 and no completion can occur.
- Throughput: WORD_W=32 with block_ready held high sustains 1 word/cycle, i.e. 1 block per 4 cycles, with no bubbles.
- Both slots full: word_ready=0 until a release. word_ready returns to 1 in the cycle after the release edge.
- partial = (wcnt != 0).
- clear has priority over accept and release in the same edge:
  - full=00, wcnt=0, wr_sel=rd_sel=0.
  - Slot data is not cleared.
  - block_cnt is held, not incremented even if block_ready was high.
- Reset during a partial fill discards the partial words. The next accepted word after reset lands in byte 0 of slot 0.
- Stimulus contract: word_in must be stable while word_valid=1 and word_ready=0; the bench does not rely on the loader tolerating anything else.

Test Plan:
1. Single block load. WORD_W=32, block_ready=0. Send 0x6c756b65, 0x696d796f, 0x75726661, 0x74686572 on consecutive cycles.
   -> block_valid rises the cycle after the 4th accept; state_array_out[0]=6c, [1]=75, [4]=69, [15]=72.
   -> Feeding sub_byte from it gives sub_byte out[0]=50, [1]=9d, [2]=7f, [3]=4d, [4]=f9.
2. Backpressure. Hold block_ready=0 and send 12 words back-to-back.
   -> word_ready drops after the 8th accept; words 9-12 stall; block 1 data is unchanged throughout.
   -> Raise block_ready for one cycle: block_cnt=1, block 2 appears, word_ready=1 in the next cycle.
3. Streaming. block_ready=1 and 8 words with valid always high.
   -> Two blocks released 4 cycles apart, block_cnt=2, word_ready never low.
4. clear mid-fill. Send 2 words, then pulse clear, then send 4 new words 0x00112233..0xccddeeff.
   -> partial=1 before clear and 0 after; the block shows [0]=00, [15]=ff; block_cnt unchanged by clear.
5. Async reset. Assert n_rst low mid-clock while block_valid=1 and wcnt=3.
   -> Outputs go to reset values immediately, without waiting for clk.
   -> The next 4 words form a block in slot 0.
6. WORD_W=8 build. Send 16 bytes 0x00..0x0f.
   -> block_valid the cycle after the 16th accept; state_array_out[i]=i for all i; partial=1 after bytes 1-15.
